mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Iterative multiply/divide unit with the HI/LO register pair; sits directly downstream of the register bank and consumes its two read-data outputs (DR1 → A, DR2 → B) for MULT/MULTU/DIV/DIVU. HI/LO are also written directly by MTHI/MTLO and read by MFHI/MFLO. The result is produced over 34 cycles behind a Busy/Done handshake that the control unit uses to stall.

## Interface
- WIDTH, 32, operand and HI/LO width; the design is verified only at 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  launch the operation in Op on A/B; sampled only in IDLE or DONE.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  32  operand rs (from DR1).
- B  in  32  operand rt (from DR2).
- WrHI  in  1  MTHI: HI ← WD.
- WrLO  in  1  MTLO: LO ← WD.
- WD  in  32  direct write data.
- HI  out  32  HI register; holds the product high word or the remainder.
- LO  out  32  LO register; holds the product low word or the quotient.
- Busy  out  1  operation in progress (CALC or FIX).
- Done  out  1  one-cycle pulse; HI/LO hold the new result.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE/DONE with Start=1 → CALC; otherwise DONE → IDLE and IDLE holds.
  - CALC → FIX when the iteration counter reaches 31.
  - FIX → DONE.
- On launch:
  - Latch Op and both operand signs.
  - Load |A| and |B|: signed ops (00, 10) take the two's-complement magnitude; unsigned ops take the raw value.
  - Clear the 64-bit accumulator; counter ← 0.
- CALC, multiply: shift-add, one multiplier bit per cycle, LSB first; 32 iterations.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first; 32 iterations.
- FIX, sign correction:
  - Negate the product if the operand signs differ (signed ops only).
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A) (signed only).
- FIX writes HI/LO.
- Divide-by-zero (B==0, DIV or DIVU):
  - Takes the full latency.
  - FIX forces HI=A (unmodified) and LO=32'hFFFFFFFF.
- Overflow: DIV 32'h80000000 / 32'hFFFFFFFF gives LO=32'h80000000, HI=0; no trap.
- All products and quotients wrap modulo 2^64 and 2^32; no exceptions are raised.
- WrHI/WrLO:
  - Honoured only when Busy=0.
  - Ignored while Busy=1; the control unit stalls.
  - Writing in DONE overrides that register's fresh result.
- Start while Busy=1 is ignored; there is no abort.
- WrHI/WrLO together with Start in the same cycle: the direct write lands; the launched operation later overwrites both registers.

## Timing
- Reset (async, rst_n=0): state=IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0, accumulator=0.
- Start sampled at edge k:
  - Busy=1 from edge k.
  - CALC occupies edges k+1 … k+32.
  - FIX occurs at edge k+33.
  - Edge k+34: DONE, Done=1, Busy=0, HI/LO final.
  - Edge k+35: IDLE, Done=0, unless a new Start was taken at k+34.
- HI/LO change only at the FIX→DONE edge or on a direct write; they are stable at all other times.
- Back-to-back: Start asserted in DONE launches the next operation at edge k+34; Done still pulses for that cycle.
- Reset mid-operation: the operation is abandoned and all outputs return to their reset values asynchronously.

## Structure
- Shared package (`mips_pkg`): Op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU, FSM state enum, DIVZERO_LO = 32'hFFFFFFFF.
- One natural sub-module, `mdu_datapath`:
  - Holds the accumulator, the shift/add/subtract step, and the counter.
  - The top level holds the FSM, sign latches, FIX logic and HI/LO.

## Test plan
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF → Done at cycle 34: HI=32'hFFFFFFFE, LO=32'h00000001.
- MULT A=-7 (32'hFFFFFFF9), B=3 → HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. DIV A=-7, B=2 → LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- DIVU A=100, B=0 → HI=100, LO=32'hFFFFFFFF. DIV A=32'h80000000, B=-1 → LO=32'h80000000, HI=0.
- Launch DIVU 100/7, then pulse Start (different operands) and WrHI at cycle 10 → both ignored; Busy stays 1; result HI=2, LO=14.
- Pull rst_n low at cycle 15 of a MULT → HI=LO=0, Busy=Done=0 immediately. After release, MULTU 6×7 → LO=42, HI=0.
- Start in the DONE cycle: MULTU 3×4 then DIVU 9/2 → first Done with LO=12, second Done 34 cycles later with LO=4, HI=1. WrLO in IDLE with WD=5 → LO=5 next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode encodings, MDU state type and constants
package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  // MULT and DIV work on signed operands; bit 0 of the opcode marks the unsigned forms
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // bit 1 of the opcode selects the divide family
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// rtl/mdu_datapath.sv - MDU accumulator, iteration counter and shift-add / restoring-divide step
module mdu_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               cnt_done
);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [CW-1:0]      cnt;
  logic [CW-2:0]      idx;
  logic [CW-2:0]      ridx;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_sub;
  logic               no_borrow;
  logic [2*WIDTH-1:0] acc_next;

  // the counter runs 0..WIDTH; its top bit marks that every iteration has been done
  assign idx      = cnt[CW-2:0];
  assign ridx     = ~idx;
  assign cnt_done = cnt[CW-1];

  // one iteration: multiply adds the multiplicand into the high half and shifts right,
  // divide shifts the next dividend bit into the partial remainder and trial-subtracts
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[idx] ? {1'b0, op_a} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], op_a[ridx]};
    no_borrow = (rem_shift >= {1'b0, op_b});
    // when the subtraction succeeds the true difference is below op_b, so WIDTH bits suffice
    rem_sub   = rem_shift[WIDTH-1:0] - op_b;
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (no_borrow) begin
        acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // operand capture at launch, then one step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (load) begin
      op_a <= mag_a;
      op_b <= mag_b;
      acc  <= '0;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_next;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with HI/LO registers and Busy/Done handshake
module mdu_hilo
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WrHI,
  input  logic             WrLO,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  mdu_state_t         state;
  mdu_state_t         state_next;
  logic               launch;
  logic               busy_int;
  logic [1:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic               cnt_done;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               sgn;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic signed_op);
    return (signed_op && x[WIDTH-1]) ? -x : x;
  endfunction

  assign busy_int = (state == ST_CALC) || (state == ST_FIX);
  assign launch   = Start && !busy_int;
  assign Busy     = busy_int;
  assign Done     = (state == ST_DONE);
  assign mag_a    = magnitude(A, is_signed_op(Op));
  assign mag_b    = magnitude(B, is_signed_op(Op));
  assign sgn      = is_signed_op(op_q);

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (launch),
    .step     ((state == ST_CALC) && !cnt_done),
    .is_div   (is_div_op(op_q)),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .acc      (acc),
    .cnt_done (cnt_done)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: CALC waits for the datapath to finish all iterations, FIX is a single cycle
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (Start) state_next = ST_CALC;
      ST_CALC: if (cnt_done) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = Start ? ST_CALC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // launch-time capture of opcode, signs and the raw dividend for the divide-by-zero result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
    end else if (launch) begin
      op_q   <= Op;
      sign_a <= A[WIDTH-1];
      sign_b <= B[WIDTH-1];
      b_zero <= (B == '0);
      a_raw  <= A;
    end
  end

  // sign correction of the unsigned magnitude result, plus the divide-by-zero override
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (is_div_op(op_q)) begin
      if (b_zero) begin
        fix_hi = a_raw;
        fix_lo = DIVZERO_LO[WIDTH-1:0];
      end else begin
        if (sgn && (sign_a ^ sign_b)) fix_lo = -acc[WIDTH-1:0];
        if (sgn && sign_a)            fix_hi = -acc[2*WIDTH-1:WIDTH];
      end
    end else if (sgn && (sign_a ^ sign_b)) begin
      {fix_hi, fix_lo} = -acc;
    end
  end

  // HI/LO: result written on FIX->DONE, direct writes only while not busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI <= '0;
      LO <= '0;
    end else if (state == ST_FIX) begin
      HI <= fix_hi;
      LO <= fix_lo;
    end else if (!busy_int) begin
      if (WrHI) HI <= WD;
      if (WrLO) LO <= WD;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo with a result scoreboard
`timescale 1ns/1ps
module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  logic [63:0] exp_q[$];
  int          total;
  int          bad;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  mdu_hilo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (start),
    .Op    (op),
    .A     (a),
    .B     (b),
    .WrHI  (wr_hi),
    .WrLO  (wr_lo),
    .WD    (wd),
    .HI    (hi),
    .LO    (lo),
    .Busy  (busy),
    .Done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // drive Start for one edge; returns 1ns after the launch edge
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // wait (bounded) for Done; elapsed counts edges since the launch edge
  task automatic wait_done(input string tag, input int elapsed);
    int n;
    bit found;
    n = elapsed;
    found = 0;
    while (n < 60 && !found) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) found = 1;
    end
    check({tag, "_latency"}, n, 34);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    check({tag, "_hi"}, hi, e[63:32]);
    check({tag, "_lo"}, lo, e[31:0]);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] expv);
    exp_q.push_back(expv);
    launch(o, x, y);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(tag, 0);
    check_result(tag);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #3 rst_n = 1'b1;

    // direct write in IDLE
    wr_lo = 1'b1; wd = 32'd5;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    check("mtlo_lo", lo, 32'd5);
    check("mtlo_hi", hi, 32'd0);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    // direct write in DONE overrides only the written register
    wr_hi = 1'b1; wd = 32'h00001234;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("mthi_done_hi", hi, 32'h00001234);
    check("mthi_done_lo", lo, 32'h00000001);
    check("done_drop", {31'd0, done}, 32'd0);

    run_op("mult_neg", 2'b00, 32'hFFFFFFF9, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF});
    run_op("div_zero_neg", 2'b10, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF});
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});

    // Start and WrHI while busy are both ignored
    prev_hi = hi; prev_lo = lo;
    exp_q.push_back({32'd2, 32'd14});
    launch(2'b11, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; wr_hi = 1'b1; wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0;
    check("busy_ignore_busy", {31'd0, busy}, 32'd1);
    check("busy_ignore_hi_stable", hi, prev_hi);
    check("busy_ignore_lo_stable", lo, prev_lo);
    wait_done("busy_ignore", 10);
    check_result("busy_ignore");

    // reset in the middle of a MULT
    launch(2'b00, 32'd5, 32'd9);
    repeat (14) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, {32'd0, 32'd42});

    // Start taken in the DONE cycle
    run_op("b2b_first", 2'b01, 32'd3, 32'd4, {32'd0, 32'd12});
    exp_q.push_back({32'd1, 32'd4});
    launch(2'b11, 32'd9, 32'd2);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done("b2b_second", 0);
    check_result("b2b_second");

    // random operands against the behavioural model
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      run_op($sformatf("rand%0d", i), ro, ra, rb, ref_mdu(ro, ra, rb));
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
